pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL use reset reset, synchronous, active-high; clock clock.
REQ-002 clock  input  1  rising-edge clock shared with the control unit.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_addr  output  8  instruction memory address; always equals pc.
REQ-005 imem_data  input  8  instruction word from memory, combinational on imem_addr; [7:5] opcode, [4:0] field.
REQ-006 opcode  output  3  IR[7:5]; feeds the control unit opcode input.
REQ-007 ir_field  output  5  IR[4:0]; immediate, branch offset or jump target.
REQ-008 PCEsc, BranchNE, Jump  input  1 each  registered control-unit outputs; 0 = halt, 1 = continue for PCEsc.
REQ-009 ula_zero  input  1  ALU zero flag for the current instruction.
REQ-010 halted  output  1  high while in HALT.
REQ-011 retire  output  1  one-cycle pulse, high in the cycle after an EXEC edge that completes an instruction.
REQ-012 instr_count  output  16  number of retired instructions, saturating at 16'hFFFF.

Function
REQ-013 The FSM SHALL have states FETCH, DECODE, EXEC and HALT, and SHALL advance one state per clock edge.
REQ-014 FETCH edge: IR <= imem_data, next state DECODE.
REQ-015 DECODE: opcode and ir_field SHALL be driven from IR so the registered control unit captures them at this edge; next state EXEC.
REQ-016 EXEC: control inputs SHALL be sampled only at the EXEC edge and ignored in all other states.
REQ-017 EXEC with PCEsc=0 (halt): pc is unchanged, next state HALT, and no retire pulse or count increment occurs.
REQ-018 EXEC with PCEsc=1 and Jump=1: pc <= {pc[7:5], IR[4:0]}, regardless of BranchNE.
REQ-019 EXEC with PCEsc=1, Jump=0, BranchNE=1 and ula_zero=0: pc <= pc + 1 + sign-extended IR[4:0], modulo 256.
REQ-020 All other EXEC cases (including BranchNE=1 with ula_zero=1): pc <= pc + 1, modulo 256, so 8'hFF wraps to 8'h00.
REQ-021 Every EXEC edge with PCEsc=1 SHALL assert retire for one cycle, increment instr_count (saturating), and return to FETCH.
REQ-022 HALT SHALL be absorbing: pc, IR, instr_count and outputs are held, halted=1, and only reset exits it.
REQ-023 Throughput SHALL be exactly 3 cycles per instruction with no stalls.
REQ-024 imem_addr SHALL be combinational from the pc register only, with no path from imem_data.

Reset
REQ-025 Reset SHALL set state=FETCH, pc=8'h00, IR=8'h00, instr_count=0, retire=0 and halted=0.
REQ-026 Reset SHALL take priority over every state, including HALT and mid-instruction DECODE/EXEC, and SHALL discard the in-flight instruction without a retire pulse.
REQ-027 The first fetch SHALL occur at the first edge with reset low, from address 8'h00.

Structure
REQ-028 A shared package SHALL hold the opcode constants (BNE=000, SLT=001, LW=010, SW=011, ADD=100, ADDI=101, JUMP=110, HALT=111), the state encoding, and the widths PC_W=8 and FIELD_W=5.
REQ-029 A single sub-module, pc_next, SHALL compute the next pc combinationally from pc, IR[4:0], Jump, BranchNE, ula_zero and PCEsc; the FSM, IR, pc and counter registers stay in pc_sequencer.

Verification
REQ-030 Sequential run: memory = ADD, ADD, HALT at addresses 0..2, with the control unit attached -> imem_addr sequence 0, 1, 2; retire pulses at cycles 3 and 6; halted=1 from cycle 9; instr_count=2.
REQ-031 Branch taken: pc=8'h10, IR=BNE with field 5'b11110, ula_zero=0 -> pc=8'h0F. Same case with ula_zero=1 -> pc=8'h11.
REQ-032 Jump: pc=8'hA7, IR=JUMP with field 5'h03 -> pc=8'hA3; with BranchNE also forced to 1, the result is still 8'hA3.
REQ-033 Wrap: pc=8'hFF, ADD -> pc=8'h00. Branch at pc=8'hFE with field 5'h05, not zero -> pc=8'h04.
REQ-034 Reset mid-EXEC and during HALT -> next cycle pc=0, state=FETCH, no retire pulse, instr_count=0.
REQ-035 Saturation: preload instr_count to 16'hFFFE, retire 3 instructions -> instr_count=16'hFFFF with no wrap.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared widths, opcodes and state encoding for the pc sequencer
// Purpose: constants and small helpers shared by pc_sequencer, pc_next and the bus interface.
package pc_sequencer_pkg;

    localparam int PC_W    = 8;
    localparam int FIELD_W = 5;
    localparam int OP_W    = 3;
    localparam int INSN_W  = OP_W + FIELD_W;
    localparam int CNT_W   = 16;

    typedef enum logic [OP_W-1:0] {
        OP_BNE  = 3'b000,
        OP_SLT  = 3'b001,
        OP_LW   = 3'b010,
        OP_SW   = 3'b011,
        OP_ADD  = 3'b100,
        OP_ADDI = 3'b101,
        OP_JUMP = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    // Branch offsets are two's-complement in the instruction field.
    function automatic logic [PC_W-1:0] sext_field(input logic [FIELD_W-1:0] field);
        return {{(PC_W-FIELD_W){field[FIELD_W-1]}}, field};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory and control unit bus of the pc sequencer
// Purpose: groups the instruction fetch path and the control unit handshake.
// master: the sequencer (drives imem_addr, opcode, ir_field; receives imem_data and controls)
// slave : memory + control unit side
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSN_W-1:0]  imem_data;
    logic [OP_W-1:0]    opcode;
    logic [FIELD_W-1:0] ir_field;
    logic               PCEsc;
    logic               BranchNE;
    logic               Jump;
    logic               ula_zero;

    modport master (
        output imem_addr, opcode, ir_field,
        input  imem_data, PCEsc, BranchNE, Jump, ula_zero
    );

    modport slave (
        input  imem_addr, opcode, ir_field,
        output imem_data, PCEsc, BranchNE, Jump, ula_zero
    );
endinterface

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next program counter
// Purpose: selects hold / jump / taken branch / increment for the EXEC edge.
// Ports: pc, field (IR[4:0]), Jump, BranchNE, ula_zero, PCEsc in; pc_nxt out.
module pc_next
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [FIELD_W-1:0] field,
    input  logic               Jump,
    input  logic               BranchNE,
    input  logic               ula_zero,
    input  logic               PCEsc,
    output logic [PC_W-1:0]    pc_nxt
);

    logic [PC_W-1:0] pc_inc;

    always_comb begin
        pc_inc = pc + 8'd1;
        pc_nxt = pc_inc;
        if (!PCEsc) begin
            pc_nxt = pc;
        end else if (Jump) begin
            // Jump stays inside the current 32-word page and wins over BranchNE.
            pc_nxt = {pc[PC_W-1:FIELD_W], field};
        end else if (BranchNE && !ula_zero) begin
            pc_nxt = pc_inc + sext_field(field);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - three-cycle fetch/decode/exec program counter sequencer
// Purpose: owns pc, IR, the FSM and the retired-instruction counter.
// Ports: clock, reset (sync, active-high); bus (master) to memory and control unit;
//        halted, retire (one-cycle pulse), instr_count (saturating).
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    pc_sequencer_if.master     bus,
    output logic               halted,
    output logic               retire,
    output logic [CNT_W-1:0]   instr_count
);

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [INSN_W-1:0]   ir;
    logic [PC_W-1:0]     pc_nxt;

    assign bus.imem_addr = pc;
    assign bus.opcode    = ir[INSN_W-1:FIELD_W];
    assign bus.ir_field  = ir[FIELD_W-1:0];

    pc_next u_pc_next (
        .pc       (pc),
        .field    (ir[FIELD_W-1:0]),
        .Jump     (bus.Jump),
        .BranchNE (bus.BranchNE),
        .ula_zero (bus.ula_zero),
        .PCEsc    (bus.PCEsc),
        .pc_nxt   (pc_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            retire      <= 1'b0;
            halted      <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_FETCH: begin
                    ir    <= bus.imem_data;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // opcode/ir_field are already stable from IR; control unit captures here.
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc <= pc_nxt;
                    if (bus.PCEsc) begin
                        retire <= 1'b1;
                        if (instr_count != {CNT_W{1'b1}}) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        state <= ST_FETCH;
                    end else begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        halted;
    logic        retire;
    logic [15:0] instr_count;
    logic [7:0]  mem [0:255];

    int n_cmp;
    int n_bad;
    logic [7:0] m_pc;
    int         m_count;
    logic       m_halted;

    pc_sequencer_if bus();
    assign bus.imem_data = mem[bus.imem_addr];

    pc_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.master),
        .halted      (halted),
        .retire      (retire),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic junk();
        bus.PCEsc    = 1'($urandom);
        bus.BranchNE = 1'($urandom);
        bus.Jump     = 1'($urandom);
        bus.ula_zero = 1'($urandom);
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [7:0] insn,
                                              input logic pcesc, input logic jmp,
                                              input logic bne, input logic uz);
        int f;
        int off;
        f = int'(insn) % 32;
        if (!pcesc) return pc;
        if (jmp) return 8'((int'(pc) / 32) * 32 + f);
        if (bne && !uz) begin
            off = (f >= 16) ? f - 32 : f;
            return 8'((int'(pc) + 1 + off + 256) % 256);
        end
        return 8'((int'(pc) + 1) % 256);
    endfunction

    // Entered and left at the falling edge of a FETCH cycle.
    task automatic run_instr(input logic pcesc, input logic jmp, input logic bne, input logic uz);
        logic [7:0] insn;
        insn = mem[m_pc];
        check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        junk();
        @(posedge clock); @(negedge clock);
        check("opcode", 32'(bus.opcode), 32'(insn[7:5]));
        check("ir_field", 32'(bus.ir_field), 32'(insn[4:0]));
        check("retire_one_cycle", 32'(retire), 32'(0));
        junk();
        @(posedge clock); @(negedge clock);
        bus.PCEsc    = pcesc;
        bus.Jump     = jmp;
        bus.BranchNE = bne;
        bus.ula_zero = uz;
        @(posedge clock); @(negedge clock);
        m_pc = model_next(m_pc, insn, pcesc, jmp, bne, uz);
        if (pcesc) begin
            if (m_count < 65535) m_count++;
        end else begin
            m_halted = 1'b1;
        end
        check("retire", 32'(retire), 32'(pcesc));
        check("halted", 32'(halted), 32'(m_halted));
        check("instr_count", 32'(instr_count), 32'(m_count));
        check("next_pc", 32'(bus.imem_addr), 32'(m_pc));
    endtask

    // Entered at a falling edge; caller may preset the controls beforehand.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("rst_pc", 32'(bus.imem_addr), 32'(0));
        check("rst_retire", 32'(retire), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_count", 32'(instr_count), 32'(0));
        reset    = 1'b0;
        m_pc     = 8'h00;
        m_count  = 0;
        m_halted = 1'b0;
    endtask

    task automatic hold_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            junk();
            @(posedge clock); @(negedge clock);
            check("hold_halted", 32'(halted), 32'(1));
            check("hold_retire", 32'(retire), 32'(0));
            check("hold_pc", 32'(bus.imem_addr), 32'(m_pc));
            check("hold_count", 32'(instr_count), 32'(m_count));
        end
    endtask

    task automatic control_unit(input logic [7:0] insn, output logic pcesc, output logic jmp,
                                output logic bne, output logic uz);
        pcesc = (insn[7:5] != 3'b111);
        jmp   = (insn[7:5] == 3'b110);
        bne   = (insn[7:5] == 3'b000);
        uz    = 1'($urandom);
    endtask

    initial begin
        logic pcesc, jmp, bne, uz;
        logic [7:0] pc_before;
        int v10, va7, vfe, guard;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        junk();
        for (int a = 0; a < 256; a++) mem[a] = 8'h80;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_pc", 32'(bus.imem_addr), 32'(0));
        check("reset_opcode", 32'(bus.opcode), 32'(0));
        check("reset_field", 32'(bus.ir_field), 32'(0));
        check("reset_halted", 32'(halted), 32'(0));
        check("reset_retire", 32'(retire), 32'(0));
        check("reset_count", 32'(instr_count), 32'(0));

        // Sequential ADD, ADD, HALT with a simple control unit attached
        mem[0] = 8'h80; mem[1] = 8'h80; mem[2] = 8'hE0;
        reset = 1'b0;
        bus.Jump = 1'b0; bus.BranchNE = 1'b0; bus.ula_zero = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            bus.PCEsc = (bus.opcode != 3'b111);
            @(posedge clock); @(negedge clock);
            check("seq_addr", 32'(bus.imem_addr), 32'((k < 3) ? 0 : (k < 6) ? 1 : 2));
            check("seq_retire", 32'(retire), 32'((k == 3 || k == 6) ? 1 : 0));
            check("seq_halted", 32'(halted), 32'((k >= 9) ? 1 : 0));
        end
        check("seq_count", 32'(instr_count), 32'(2));
        mem[2] = 8'h80;

        // Reset out of HALT, then reset in the middle of EXEC
        do_reset();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        bus.PCEsc = 1'b1; bus.Jump = 1'b0; bus.BranchNE = 1'b0;
        do_reset();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0);

        // Saturating counter
        do_reset();
        force dut.instr_count = 16'hFFFE;
        #1;
        release dut.instr_count;
        m_count = 32'hFFFE;
        for (int i = 0; i < 3; i++) run_instr(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_count", 32'(instr_count), 32'h0000_FFFF);

        // Directed walk: branch both ways, jump with and without BranchNE, wrap
        for (int a = 0; a < 256; a++) mem[a] = 8'h80;
        mem[8'h10] = 8'h1E;
        mem[8'hA7] = 8'hC3;
        mem[8'hFE] = 8'h05;
        v10 = 0; va7 = 0; vfe = 0; guard = 0;
        do_reset();
        while (!m_halted && guard < 700) begin
            guard++;
            control_unit(mem[m_pc], pcesc, jmp, bne, uz);
            pc_before = m_pc;
            if (pc_before == 8'h10 && bne) begin uz = (v10 != 0); v10++; end
            if (pc_before == 8'hA7 && jmp) begin bne = (va7 != 0); va7++; end
            if (pc_before == 8'hFE && bne) begin uz = (vfe == 0); vfe++; end
            run_instr(pcesc, jmp, bne, uz);
            if (pc_before == 8'h10 && mem[8'h10] == 8'h1E) begin
                check("bne_at_10", 32'(bus.imem_addr), 32'(uz ? 8'h11 : 8'h0F));
                if (v10 == 2) mem[8'h10] = 8'h80;
            end
            if (pc_before == 8'hA7 && mem[8'hA7] == 8'hC3) begin
                check("jump_at_a7", 32'(bus.imem_addr), 32'(8'hA3));
                if (va7 == 2) mem[8'hA7] = 8'h80;
            end
            if (pc_before == 8'hFE) begin
                check("bne_at_fe", 32'(bus.imem_addr), 32'(uz ? 8'hFF : 8'h04));
                if (!uz) mem[8'h08] = 8'hE0;
            end
            if (pc_before == 8'hFF) check("wrap_ff", 32'(bus.imem_addr), 32'(0));
        end
        check("walk_halted", 32'(halted), 32'(1));
        hold_check(4);
        mem[8'h08] = 8'h80;

        // Random programs against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            do_reset();
            for (int n = 0; n < 150 && !m_halted; n++) begin
                control_unit(mem[m_pc], pcesc, jmp, bne, uz);
                if ($urandom_range(0, 3) == 0) bne = 1'($urandom);
                if ($urandom_range(0, 31) == 0) pcesc = 1'b0;
                run_instr(pcesc, jmp, bne, uz);
            end
            if (m_halted) hold_check(3);
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
